// File: rtl/quadrature_decoder_pkg.sv
// Shared types, defaults and Gray-step decode for the quadrature decoder.
package quadrature_decoder_pkg;

  localparam int unsigned DefFilterLen   = 3;
  localparam logic [7:0]  DefIndexPreset = 8'h00;

  typedef enum logic [0:0] {
    StInit,
    StTrack
  } dec_state_e;

  typedef struct packed {
    logic step_up;
    logic step_down;
    logic illegal;
  } step_t;

  // Forward order 00,01,11,10 maps onto positions 0..3.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic step_t gray_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t      s;
    logic [1:0] delta;
    delta       = gray_pos(cur) - gray_pos(prev);
    s.step_up   = (delta == 2'd1);
    s.step_down = (delta == 2'd3);
    s.illegal   = (delta == 2'd2);
    return s;
  endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Count command bus from the decoder to the downstream up/down position counter.
interface quadrature_decoder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             up;
  logic             down;
  logic             load;
  logic [WIDTH-1:0] preset;

  modport master (output up, down, load, preset);
  modport slave  (input  up, down, load, preset);
endinterface

// File: rtl/quad_chan_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one encoder channel.
module quad_chan_filter
  import quadrature_decoder_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DefFilterLen
) (
  input  logic clock,
  input  logic clear_n,
  input  logic raw_i,
  output logic filt_o,
  output logic stable_o
);

  localparam logic [3:0] Len = 4'(FILTER_LEN);

  logic       sync1_q, sync2_q, filt_q;
  logic [3:0] run_q, agree_q;

  // agree_q counts consecutive samples equal to filt_q, saturating at Len. An accepted
  // change was itself Len identical samples, so it starts the count already saturated.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      run_q   <= 4'd0;
      agree_q <= 4'd0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q != filt_q) begin
        agree_q <= 4'd0;
        if (run_q == Len - 4'd1) begin
          filt_q  <= sync2_q;
          run_q   <= 4'd0;
          agree_q <= Len;
        end else begin
          run_q <= run_q + 4'd1;
        end
      end else begin
        run_q <= 4'd0;
        if (agree_q != Len) agree_q <= agree_q + 4'd1;
      end
    end
  end

  assign filt_o   = filt_q;
  assign stable_o = (agree_q == Len);

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B/Z decoder producing one-cycle up/down/load commands for a position counter.
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int unsigned      FILTER_LEN   = DefFilterLen,
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] INDEX_PRESET = WIDTH'(DefIndexPreset)
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 enc_z,
  input  logic                 index_en,
  input  logic                 err_clr,
  quadrature_decoder_if.master cmd,
  output logic                 dir,
  output logic                 error
);

  logic a_filt, b_filt, z_filt;
  logic a_stable, b_stable, z_stable;

  quad_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clock   (clock),
    .clear_n (clear_n),
    .raw_i   (enc_a),
    .filt_o  (a_filt),
    .stable_o(a_stable)
  );

  quad_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clock   (clock),
    .clear_n (clear_n),
    .raw_i   (enc_b),
    .filt_o  (b_filt),
    .stable_o(b_stable)
  );

  quad_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (
    .clock   (clock),
    .clear_n (clear_n),
    .raw_i   (enc_z),
    .filt_o  (z_filt),
    .stable_o(z_stable)
  );

  dec_state_e state_q;
  logic [1:0] ab_prev_q;
  logic       z_prev_q;
  logic       up_q, down_q, load_q, dir_q, error_q;

  logic [1:0] ab_filt;
  step_t      step;
  logic       index_hit;

  assign ab_filt   = {a_filt, b_filt};
  assign step      = gray_step(ab_prev_q, ab_filt);
  assign index_hit = index_en && z_filt && !z_prev_q;

  // Baselines follow the filtered pins in both states, so TRACK starts from the settled value.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q   <= StInit;
      ab_prev_q <= 2'b00;
      z_prev_q  <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      load_q    <= 1'b0;
      dir_q     <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      load_q    <= 1'b0;
      ab_prev_q <= ab_filt;
      z_prev_q  <= z_filt;
      if (err_clr) error_q <= 1'b0;
      unique case (state_q)
        StInit: begin
          if (a_stable && b_stable && z_stable) state_q <= StTrack;
        end
        StTrack: begin
          if (step.illegal) error_q <= 1'b1;
          if (index_hit) begin
            load_q <= 1'b1;
          end else begin
            up_q   <= step.step_up;
            down_q <= step.step_down;
          end
          if (step.step_up) begin
            dir_q <= 1'b1;
          end else if (step.step_down) begin
            dir_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign cmd.up     = up_q;
  assign cmd.down   = down_q;
  assign cmd.load   = load_q;
  assign cmd.preset = INDEX_PRESET;
  assign dir        = dir_q;
  assign error      = error_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: vector table, corner sequences, random steps.
module tb_quadrature_decoder;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  // Pins driven just after edge n are first sampled at edge n+1; strobe shows after n+6.
  localparam int Lat = 6;

  logic clock, clear_n, enc_a, enc_b, enc_z, index_en, err_clr;
  logic dir, error;

  quadrature_decoder_if #(.WIDTH(8)) cmd_if ();

  quadrature_decoder #(
    .FILTER_LEN  (3),
    .WIDTH       (8),
    .INDEX_PRESET(8'h00)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .enc_z   (enc_z),
    .index_en(index_en),
    .err_clr (err_clr),
    .cmd     (cmd_if),
    .dir     (dir),
    .error   (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] ab;
    logic       z;
    logic       en;
    logic       up;
    logic       down;
    logic       load;
    logic       dir;
    logic       err;
  } vec_t;

  vec_t       vecs[$];
  int         cyc, n_cmp, n_bad;
  bit         exp_up[int], exp_dn[int], exp_ld[int];
  logic [7:0] pos;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %02h, want %02h", name, cyc, act, exp);
    end
  endtask

  // One clock; every strobe is compared against the schedule, then feeds a downstream counter.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    check_bit("up", cmd_if.up, exp_up.exists(cyc) != 0);
    check_bit("down", cmd_if.down, exp_dn.exists(cyc) != 0);
    check_bit("load", cmd_if.load, exp_ld.exists(cyc) != 0);
    if (cmd_if.load) pos = cmd_if.preset;
    else if (cmd_if.up) pos = pos + 8'd1;
    else if (cmd_if.down) pos = pos - 8'd1;
  endtask

  task automatic add(input logic [1:0] ab, input logic z, input logic en, input logic u,
                     input logic d, input logic ld, input logic dr, input logic er);
    vec_t v;
    v.ab = ab; v.z = z; v.en = en; v.up = u; v.down = d; v.load = ld; v.dir = dr; v.err = er;
    vecs.push_back(v);
  endtask

  task automatic drive_ab(input logic [1:0] ab);
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  logic [1:0] gray[4];
  int         p, model_pos;
  logic       model_dir, go_up;

  initial begin
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    cyc = 0; n_cmp = 0; n_bad = 0; pos = 8'h00;
    clear_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1; enc_z = 1'b0; index_en = 1'b1; err_clr = 1'b0;

    //           ab     z  en up dn ld dir err
    add(2'b10, L, H, H, L, L, H, L);   // 11->10 forward
    add(2'b00, L, H, H, L, L, H, L);
    add(2'b01, L, H, H, L, L, H, L);
    add(2'b11, L, H, H, L, L, H, L);
    add(2'b10, L, H, H, L, L, H, L);
    add(2'b00, L, H, H, L, L, H, L);
    add(2'b10, L, H, L, H, L, L, L);   // reverse run
    add(2'b11, L, H, L, H, L, L, L);
    add(2'b01, L, H, L, H, L, L, L);
    add(2'b00, L, H, L, H, L, L, L);
    add(2'b00, H, H, L, L, H, L, L);   // index alone
    add(2'b00, L, H, L, L, L, L, L);   // Z fall: nothing
    add(2'b01, H, H, L, L, H, H, L);   // index with forward step: load only, dir updates
    add(2'b01, L, H, L, L, L, H, L);
    add(2'b01, H, L, L, L, L, H, L);   // index disabled
    add(2'b01, L, L, L, L, L, H, L);
    add(2'b10, L, H, L, L, L, H, H);   // 01->10 illegal

    // Reset held with A=B=1.
    for (int i = 0; i < 3; i++) tick();
    check_bit("rst up", cmd_if.up, 1'b0);
    check_bit("rst down", cmd_if.down, 1'b0);
    check_bit("rst load", cmd_if.load, 1'b0);
    check_bit("rst dir", dir, 1'b0);
    check_bit("rst error", error, 1'b0);
    clear_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check_bit("init error", error, 1'b0);
    check_bit("init dir", dir, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 6) pos = 8'h05;
      drive_ab(vecs[i].ab);
      enc_z    = vecs[i].z;
      index_en = vecs[i].en;
      if (vecs[i].up)   exp_up[cyc + Lat] = 1'b1;
      if (vecs[i].down) exp_dn[cyc + Lat] = 1'b1;
      if (vecs[i].load) exp_ld[cyc + Lat] = 1'b1;
      for (int j = 1; j <= 8; j++) begin
        tick();
        if (j == Lat) begin
          check_bit($sformatf("vec%0d dir", i), dir, vecs[i].dir);
          check_bit($sformatf("vec%0d error", i), error, vecs[i].err);
          if (vecs[i].load) check_byte($sformatf("vec%0d preset", i), cmd_if.preset, 8'h00);
        end
      end
      if (i == 9) check_byte("reverse count", pos, 8'h01);
      if (i == 10) check_byte("index count", pos, 8'h00);
    end
    index_en = 1'b1;

    // err_clr alone clears the sticky flag.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_bit("err_clr", error, 1'b0);

    // Glitches on A from baseline 10: 2 samples rejected, 3 samples give up then down.
    drive_ab(2'b00);
    tick(); tick();
    drive_ab(2'b10);
    for (int i = 0; i < 10; i++) tick();
    check_bit("glitch2 error", error, 1'b0);
    drive_ab(2'b00);
    exp_up[cyc + Lat] = 1'b1;
    tick(); tick(); tick();
    drive_ab(2'b10);
    exp_dn[cyc + Lat] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_bit("glitch3 error", error, 1'b0);

    // Illegal step landing on the same cycle as err_clr: set wins.
    drive_ab(2'b01);
    for (int i = 0; i < Lat - 1; i++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_bit("set beats clr", error, 1'b1);
    tick(); tick();
    check_bit("error sticky", error, 1'b1);

    // Random legal steps against an arithmetic position model.
    p = 1; pos = 8'h00; model_pos = 0; model_dir = dir;
    for (int s = 0; s < 40; s++) begin
      go_up = ($urandom_range(0, 1) == 1);
      p = go_up ? (p + 1) % 4 : (p + 3) % 4;
      model_pos = go_up ? model_pos + 1 : model_pos - 1;
      model_dir = go_up;
      drive_ab(gray[p]);
      if (go_up) exp_up[cyc + Lat] = 1'b1;
      else exp_dn[cyc + Lat] = 1'b1;
      for (int d = $urandom_range(4, 9); d > 0; d--) tick();
    end
    for (int i = 0; i < 8; i++) tick();
    check_byte("random count", pos, 8'(model_pos));
    check_bit("random dir", dir, model_dir);

    // Reset while a step is still in the filter: no strobe for it.
    p = (p + 1) % 4;
    drive_ab(gray[p]);
    tick(); tick(); tick();
    clear_n = 1'b0;
    tick(); tick();
    clear_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check_bit("midreset dir", dir, 1'b0);
    check_bit("midreset error", error, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
